// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; occupancy tracked by a counter.
// Push on full and pop on empty are ignored; read data is the current head (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clock,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop)
            level_d = level_q + 1'b1;
        else if (do_pop && !do_push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop serialiser.
// First start bit one cycle after a push into an idle block; frames run back to back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clock,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic [1:0]             parity_mode,
    input  logic                   stop2,
    input  logic                   clr_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   uart_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             mode_q, mode_d;
    logic                   stop2_q, stop2_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   ovf_q;
    logic                   pop;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   head_dat;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .RESET      (RESET),
        .push_i     (wr_en),
        .push_dat_i (wr_data),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level)
    );

    assign bit_end = (baud_q == LAST_BAUD);

    always_comb begin
        state_d    = state_q;
        baud_d     = (state_q == ST_IDLE || bit_end) ? '0 : baud_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_START: if (bit_end) begin
                state_d = ST_DATA;
                tx_d    = shift_q[0];
                bit_d   = '0;
            end
            ST_DATA: if (bit_end) begin
                if (bit_q == LAST_BIT) begin
                    if (mode_q == PAR_EVEN || mode_q == PAR_ODD) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d    = ST_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    bit_d   = bit_q + 1'b1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d    = ST_STOP;
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
            end
            ST_STOP: if (bit_end) begin
                if (stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Loading a new frame: from IDLE, or straight out of the final stop bit.
        if (state_d == ST_IDLE && !empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
            baud_d  = '0;
            shift_d = head_dat;
            mode_d  = parity_mode;
            stop2_d = stop2;
            par_d   = (^head_dat) ^ (parity_mode == PAR_ODD);
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            ovf_q      <= (ovf_q & ~clr_overflow) | (wr_en & full);
        end
    end

    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);
    assign uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4, DATA_BITS=8.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [1:0] parity_mode = 2'd0;
    logic       stop2 = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       full, empty, overflow, busy, uart_tx;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_n;
    logic exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        s2;
        logic [15:0] pat;   // expected line level per bit, bit 0 = start bit
        int          nbits;
    } vec_t;

    vec_t vecs[7];

    uart_tx_fifo #(.DATA_BITS(8), .DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clock        (clk),
        .RESET        (RESET),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .parity_mode  (parity_mode),
        .stop2        (stop2),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic add_frame(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
    endtask

    // Called at the negedge right after the start-bit edge; ends at the negedge after the last bit.
    task automatic check_stream(input string nm, input bit flip);
        int bad = 0;
        int busy_bad = 0;
        int total = exp_q.size() * CPB;
        for (int k = 0; k < total; k++) begin
            if (k == 1) wr_en = 1'b0;
            if (flip && k == 8) begin
                stop2 = ~stop2;
                parity_mode = parity_mode ^ 2'b11;
            end
            if (uart_tx !== exp_q[k / CPB]) begin
                if (bad == 0)
                    $display("FAIL %s line at cycle %0d: got %b expected %b", nm, k, uart_tx, exp_q[k / CPB]);
                bad++;
            end
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        chk({nm, " line mismatches"}, bad, 0);
        chk({nm, " busy drops"}, busy_bad, 0);
        chk({nm, " idle busy"}, {31'd0, busy}, 0);
        chk({nm, " idle line"}, {31'd0, uart_tx}, 1);
    endtask

    initial begin
        vecs[0] = '{8'h55, 2'd0, 1'b0, 16'h02AA, 10};
        vecs[1] = '{8'h07, 2'd1, 1'b0, 16'h060E, 11};
        vecs[2] = '{8'h07, 2'd2, 1'b0, 16'h040E, 11};
        vecs[3] = '{8'hFF, 2'd0, 1'b1, 16'h07FE, 11};
        vecs[4] = '{8'h00, 2'd1, 1'b1, 16'h0C00, 12};
        vecs[5] = '{8'h80, 2'd2, 1'b0, 16'h0500, 11};
        vecs[6] = '{8'h0F, 2'd3, 1'b0, 16'h021E, 10};

        repeat (3) @(negedge clk);
        RESET = 1'b0;
        chk("reset tx", {31'd0, uart_tx}, 1);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset level", {29'd0, level}, 0);
        chk("reset empty", {31'd0, empty}, 1);
        chk("reset full", {31'd0, full}, 0);
        chk("reset overflow", {31'd0, overflow}, 0);

        // Single frames; format inputs are disturbed mid-frame to prove they are latched.
        for (int i = 0; i < 7; i++) begin
            parity_mode = vecs[i].mode;
            stop2 = vecs[i].s2;
            wr_data = vecs[i].data;
            wr_en = 1'b1;
            @(negedge clk);
            wr_en = 1'b0;
            chk($sformatf("v%0d level after push", i), {29'd0, level}, 1);
            chk($sformatf("v%0d line before start", i), {31'd0, uart_tx}, 1);
            @(negedge clk);
            exp_q.delete();
            add_frame(vecs[i].pat, vecs[i].nbits);
            check_stream($sformatf("v%0d", i), 1'b1);
        end

        // Three back-to-back frames.
        parity_mode = 2'd0;
        stop2 = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hA1;
        @(negedge clk);
        chk("burst level 1", {29'd0, level}, 1);
        wr_data = 8'hB2;
        @(negedge clk);
        chk("burst level push+pop", {29'd0, level}, 1);
        wr_data = 8'hC3;
        exp_q.delete();
        add_frame(16'h0342, 10);
        add_frame(16'h0364, 10);
        add_frame(16'h0386, 10);
        check_stream("burst", 1'b0);
        chk("burst empty after", {31'd0, empty}, 1);

        // Overflow with DEPTH=4: five accepted, sixth dropped.
        for (int j = 0; j < 6; j++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(j);
            @(negedge clk);
            if (j == 0) cyc_n = cyc;
            if (j == 4) begin
                chk("ovf full after 5th", {31'd0, full}, 1);
                chk("ovf level after 5th", {29'd0, level}, 4);
                chk("ovf clear before 6th", {31'd0, overflow}, 0);
            end
        end
        chk("ovf set by 6th", {31'd0, overflow}, 1);
        chk("ovf level kept", {29'd0, level}, 4);
        clr_overflow = 1'b1;
        @(negedge clk);
        chk("ovf set wins over clear", {31'd0, overflow}, 1);
        wr_en = 1'b0;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf cleared", {31'd0, overflow}, 0);
        begin
            int guard = 0;
            while (busy === 1'b1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            chk("ovf drained in bound", {31'd0, busy}, 0);
            chk("ovf five frames length", cyc - cyc_n, 201);
        end

        // Reset during the third data bit with two bytes still queued.
        wr_en = 1'b1;
        wr_data = 8'h3C;
        @(negedge clk);
        wr_data = 8'h5A;
        @(negedge clk);
        wr_data = 8'h96;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst queued level", {29'd0, level}, 2);
        chk("rst mid-frame busy", {31'd0, busy}, 1);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        chk("rst tx", {31'd0, uart_tx}, 1);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst level", {29'd0, level}, 0);
        chk("rst empty", {31'd0, empty}, 1);
        begin
            int act = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (uart_tx !== 1'b1 || busy !== 1'b0) act++;
            end
            chk("rst no further frames", act, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
